mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter for a shared memory, one transaction outstanding
module mem_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h80000000,
    parameter int unsigned MEM_BYTES = 8192,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        ls_req_valid,
    input  logic [31:0] ls_req_addr,
    output logic        ls_req_ready,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_data,
    output logic        ls_rsp_err,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO   = CW'(TIMEOUT);
    // Highest legal word address, computed in 33 bits so the window never wraps.
    localparam logic [32:0]   LIMIT = {1'b0, BASE_ADDR} + 33'(MEM_BYTES) - 33'd4;

    state_t        state_q;
    logic          owner_q;      // 1 = LS owns the outstanding transaction
    logic          last_grant_q; // 1 = LS was served last
    logic [CW-1:0] cnt_q;

    logic          idle;
    logic          any_valid;
    logic          sel_ls;
    logic [31:0]   sel_addr;
    logic          addr_ok;
    logic          grant;
    logic          rsp_fire;
    logic          rsp_is_err;
    logic [31:0]   rsp_word;

    // Requester selection, address legality and the combinational handshake.
    always_comb begin
        idle          = (state_q == S_IDLE) && rst_n;
        any_valid     = if_req_valid || ls_req_valid;
        sel_ls        = ls_req_valid && (!if_req_valid || !last_grant_q);
        sel_addr      = sel_ls ? ls_req_addr : if_req_addr;
        addr_ok       = (sel_addr[1:0] == 2'b00)
                     && ({1'b0, sel_addr} >= {1'b0, BASE_ADDR})
                     && ({1'b0, sel_addr} <= LIMIT);
        mem_req_valid = idle && any_valid && addr_ok;
        mem_req_addr  = sel_addr - BASE_ADDR;
        // Illegal requests are swallowed immediately without touching memory.
        grant         = idle && any_valid && (addr_ok ? mem_req_ready : 1'b1);
        if_req_ready  = grant && !sel_ls;
        ls_req_ready  = grant && sel_ls;
    end

    // Decide whether the outstanding transaction completes this cycle and with what.
    always_comb begin
        rsp_fire   = 1'b0;
        rsp_is_err = 1'b0;
        rsp_word   = 32'h0;
        case (state_q)
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    rsp_fire = 1'b1;
                    rsp_word = mem_rsp_data;
                end else if (cnt_q == TMO) begin
                    rsp_fire   = 1'b1;
                    rsp_is_err = 1'b1;
                end
            end
            S_ERR: begin
                rsp_fire   = 1'b1;
                rsp_is_err = 1'b1;
            end
            default: ;
        endcase
    end

    // Transaction FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= 32'h0;
            if_rsp_err   <= 1'b0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_data  <= 32'h0;
            ls_rsp_err   <= 1'b0;
        end else begin
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        owner_q      <= sel_ls;
                        last_grant_q <= sel_ls;
                        cnt_q        <= '0;
                        state_q      <= addr_ok ? S_WAIT : S_ERR;
                    end
                end
                S_WAIT: begin
                    if (!rsp_fire) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
            if (rsp_fire) begin
                state_q <= S_IDLE;
                if (owner_q) begin
                    ls_rsp_valid <= 1'b1;
                    ls_rsp_data  <= rsp_word;
                    ls_rsp_err   <= rsp_is_err;
                end else begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_data  <= rsp_word;
                    if_rsp_err   <= rsp_is_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, ls_req_valid;
    logic [31:0] if_req_addr, ls_req_addr;
    logic        if_req_ready, ls_req_ready;
    logic        if_rsp_valid, ls_rsp_valid;
    logic [31:0] if_rsp_data, ls_rsp_data;
    logic        if_rsp_err, ls_rsp_err;
    logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [31:0] mem_req_addr, mem_rsp_data;

    mem_arbiter #(.BASE_ADDR(32'h80000000), .MEM_BYTES(8192), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } rsp_t;

    rsp_t if_q[$];
    rsp_t ls_q[$];
    bit   grant_log[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   rsp_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Memory stub contents: word offset 4 holds 0x413, every other word is 0xC0DE<offset>.
    function automatic logic [31:0] mem_word(input logic [31:0] off);
        return (off == 32'h4) ? 32'h00000413 : {16'hC0DE, off[15:0]};
    endfunction

    // Memory responder: answers one cycle after each accepted request while enabled.
    initial begin
        logic [31:0] off;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_en && mem_req_valid && mem_req_ready) begin
                off = mem_req_addr;
                @(posedge clk); #1;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_word(off);
                @(posedge clk); #1;
                mem_rsp_valid = 1'b0;
            end
        end
    end

    // Response monitor: pops the per-port scoreboard whenever a response pulse appears.
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && if_rsp_valid) begin
            if (if_q.size() == 0) check("if_rsp_unexpected", 64'(if_rsp_data), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                e = if_q.pop_front();
                check("if_rsp", {15'b0, if_rsp_data, if_rsp_err, 16'(cyc)}, {15'b0, e.data, e.err, 16'(e.due)});
            end
        end
        if (rst_n && ls_rsp_valid) begin
            if (ls_q.size() == 0) check("ls_rsp_unexpected", 64'(ls_rsp_data), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                e = ls_q.pop_front();
                check("ls_rsp", {15'b0, ls_rsp_data, ls_rsp_err, 16'(cyc)}, {15'b0, e.data, e.err, 16'(e.due)});
            end
        end
    end

    // Drive one request on port p (0=IF, 1=LS) and register its expected outcome.
    task automatic issue(input bit p, input logic [31:0] addr, input bit legal, input logic [31:0] off,
                         input logic [31:0] d, input bit e, input int lat, input bit want_rsp);
        int   n = 0;
        bit   got = 0;
        rsp_t r;
        if (p) begin ls_req_valid = 1'b1; ls_req_addr = addr; end
        else   begin if_req_valid = 1'b1; if_req_addr = addr; end
        while (!got && n < 400) begin
            @(negedge clk);
            if (p ? ls_req_ready : if_req_ready) got = 1;
            else n++;
        end
        if (!got) begin
            check(p ? "ls_accept_timeout" : "if_accept_timeout", 64'(addr), 64'h0);
        end else begin
            check("mem_req_valid_at_accept", 64'(mem_req_valid), 64'(legal));
            if (legal) check("mem_req_addr", 64'(mem_req_addr), 64'(off));
            grant_log.push_back(p);
            r.data = d; r.err = e; r.due = cyc + lat;
            if (want_rsp) begin
                if (p) ls_q.push_back(r);
                else   if_q.push_back(r);
            end
        end
        @(posedge clk); #1;
        if (p) ls_req_valid = 1'b0;
        else   if_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((if_q.size() + ls_q.size()) != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(if_q.size() + ls_q.size()), 64'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] g;
        rst_n         = 1'b0;
        mem_req_ready = 1'b1;
        if_req_valid  = 1'b1; if_req_addr = 32'h80000000;
        ls_req_valid  = 1'b1; ls_req_addr = 32'h80000010;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl_outs", {57'b0, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
                                  if_rsp_err, ls_rsp_err, mem_req_valid}, 64'h0);
        check("reset_rsp_data", {if_rsp_data, ls_rsp_data}, 64'h0);
        rst_n = 1'b1;

        // Sustained contention from reset: IF wins the first tie, then strict alternation.
        fork
            begin
                issue(0, 32'h80000000, 1, 32'h00, 32'hC0DE0000, 0, 2, 1);
                issue(0, 32'h80000020, 1, 32'h20, 32'hC0DE0020, 0, 2, 1);
                issue(0, 32'h80000040, 1, 32'h40, 32'hC0DE0040, 0, 2, 1);
            end
            begin
                issue(1, 32'h80000010, 1, 32'h10, 32'hC0DE0010, 0, 2, 1);
                issue(1, 32'h80000030, 1, 32'h30, 32'hC0DE0030, 0, 2, 1);
                issue(1, 32'h80000050, 1, 32'h50, 32'hC0DE0050, 0, 2, 1);
            end
        join
        drain();
        g = 6'h0;
        for (int i = 0; i < grant_log.size() && i < 6; i++) g[i] = grant_log[i];
        check("grant_count", 64'(grant_log.size()), 64'd6);
        check("grant_order", 64'(g), 64'b101010);

        // Single fetch, minimum latency.
        issue(0, 32'h80000004, 1, 32'h4, 32'h00000413, 0, 2, 1);
        drain();

        // Illegal load addresses and the top legal word.
        issue(1, 32'h80000002, 0, 32'h0, 32'h0, 1, 2, 1);
        issue(1, 32'h80002000, 0, 32'h0, 32'h0, 1, 2, 1);
        issue(1, 32'h80001FFC, 1, 32'h1FFC, 32'hC0DE1FFC, 0, 2, 1);
        issue(1, 32'h7FFFFFFC, 0, 32'h0, 32'h0, 1, 2, 1);
        issue(1, 32'hFFFFFFFC, 0, 32'h0, 32'h0, 1, 2, 1);
        drain();

        // Memory back-pressure for three cycles.
        mem_req_ready = 1'b0;
        fork
            issue(0, 32'h80000040, 1, 32'h40, 32'hC0DE0040, 0, 2, 1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_hold", {30'b0, if_req_ready, mem_req_valid, mem_req_addr},
                          {30'b0, 1'b0, 1'b1, 32'h40});
                end
                @(posedge clk); #1;
                mem_req_ready = 1'b1;
            end
        join
        drain();

        // Timeout with no memory answer, then a late response that must be ignored.
        rsp_en = 1'b0;
        issue(0, 32'h80000100, 1, 32'h100, 32'h0, 1, TMO + 2, 1);
        drain();
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("late_rsp_ignored_hold", {31'b0, if_rsp_valid, if_rsp_err, if_rsp_data}, {31'b0, 1'b0, 1'b1, 32'h0});

        // Reset while waiting abandons the transaction.
        issue(0, 32'h80000008, 1, 32'h8, 32'h0, 0, 2, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("midwait_reset_outs", {57'b0, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
                                     if_rsp_err, ls_rsp_err, mem_req_valid}, 64'h0);
        check("midwait_reset_data", {if_rsp_data, ls_rsp_data}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h12345678;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        rsp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        issue(0, 32'h80000004, 1, 32'h4, 32'h00000413, 0, 2, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
